// File: rtl/moore_10010_pkg.sv
// Shared state encoding for the 10010 serial pattern detector.
package moore_10010_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    S1     = 3'd1,
    S10    = 3'd2,
    S100   = 3'd3,
    S1001  = 3'd4,
    S10010 = 3'd5
  } state_t;

endpackage

// File: rtl/moore_10010.sv
// Moore FSM that flags one cycle after the serial stream ends in 1-0-0-1-0.
// REPEAT selects whether the trailing "10" of a match may seed the next one.
module moore_10010
  import moore_10010_pkg::*;
#(
  parameter logic REPEAT = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_in,
  output logic data_out
);

  state_t state;
  state_t next_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Unused encodings 6 and 7 fall to the default arm and recover to IDLE.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = data_in ? S1    : IDLE;
      S1:      next_state = data_in ? S1    : S10;
      S10:     next_state = data_in ? S1    : S100;
      S100:    next_state = data_in ? S1001 : IDLE;
      S1001:   next_state = data_in ? S1    : S10010;
      S10010: begin
        if (data_in) begin
          next_state = S1;
        end else begin
          next_state = REPEAT ? S100 : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign data_out = (state == S10010);

endmodule

// File: tb/tb_moore_10010.sv
// Self-checking bench: both REPEAT variants driven by one stream and compared
// against a sliding-window model of the bit history plus fixed vector tables.
module tb_moore_10010;

  localparam logic [4:0] PATTERN = 5'b10010;

  typedef struct {
    bit din;
    bit ovl;
    bit nov;
  } vec_t;

  logic clk;
  logic rst_n;
  logic data_in;
  logic out_ovl;
  logic out_nov;

  int errors = 0;
  int checks = 0;

  logic [4:0] hist_ovl;
  logic [4:0] hist_nov;
  int len_ovl;
  int len_nov;
  bit exp_ovl;
  bit exp_nov;
  int det_ovl;
  int det_nov;

  vec_t vecs[25];

  moore_10010 #(.REPEAT(1'b1)) dut_ovl (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(out_ovl)
  );

  moore_10010 #(.REPEAT(1'b0)) dut_nov (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(out_nov)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    hist_ovl = '0;
    hist_nov = '0;
    len_ovl  = 0;
    len_nov  = 0;
    exp_ovl  = 1'b0;
    exp_nov  = 1'b0;
  endtask

  // Overlapping: any five most recent bits since reset; non-overlapping: only
  // bits received since the last match count toward the next one.
  task automatic model_step(input bit b);
    hist_ovl = {hist_ovl[3:0], b};
    if (len_ovl < 5) len_ovl++;
    exp_ovl = (len_ovl >= 5) && (hist_ovl == PATTERN);
    hist_nov = {hist_nov[3:0], b};
    if (len_nov < 5) len_nov++;
    exp_nov = (len_nov >= 5) && (hist_nov == PATTERN);
    if (exp_nov) len_nov = 0;
  endtask

  task automatic check_output(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input bit b);
    data_in = b;
    @(posedge clk);
    #1;
    if (rst_n) model_step(b);
    else model_reset();
    check_output("model_ovl", out_ovl, exp_ovl);
    check_output("model_nov", out_nov, exp_nov);
    if (out_ovl === 1'b1) det_ovl++;
    if (out_nov === 1'b1) det_nov++;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check_output({name, "_ovl"}, out_ovl, 1'b0);
    check_output({name, "_nov"}, out_nov, 1'b0);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [0:24] t_din;
    logic [0:24] t_ovl;
    logic [0:24] t_nov;
    logic [0:4]  seq;

    t_din = 25'b10010010_000_100010_10110_010;
    t_ovl = 25'b00001001_000_000000_00000_001;
    t_nov = 25'b00001000_000_000000_00000_001;
    for (int i = 0; i < 25; i++) begin
      vecs[i] = '{t_din[i], t_ovl[i], t_nov[i]};
    end
    seq = 5'b10010;

    det_ovl = 0;
    det_nov = 0;
    rst_n   = 1'b0;
    data_in = 1'b0;
    model_reset();

    $display("[TB] reset hold with pattern on data_in");
    for (int i = 0; i < 5; i++) apply_stimulus(seq[i]);
    rst_n = 1'b1;
    model_reset();

    $display("[TB] vector table: match, overlap, near misses");
    for (int i = 0; i < 25; i++) begin
      apply_stimulus(vecs[i].din);
      check_output($sformatf("tbl_ovl[%0d]", i), out_ovl, vecs[i].ovl);
      check_output($sformatf("tbl_nov[%0d]", i), out_nov, vecs[i].nov);
    end

    $display("[TB] reset mid-sequence");
    for (int i = 0; i < 4; i++) apply_stimulus(seq[i]);
    reset_pulse("mid_reset");
    apply_stimulus(1'b0);
    check_output("after_reset_ovl", out_ovl, 1'b0);
    check_output("after_reset_nov", out_nov, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(seq[i]);
    check_output("rematch_ovl", out_ovl, 1'b1);
    check_output("rematch_nov", out_nov, 1'b1);

    $display("[TB] reset while in match state");
    reset_pulse("match_reset");
    apply_stimulus(1'b0);

    $display("[TB] random soak");
    det_ovl = 0;
    det_nov = 0;
    for (int i = 0; i < 10000; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)));
    end
    checks++;
    if (det_ovl < det_nov) begin
      errors++;
      $display("[TB] FAIL det_count: got ovl=%0d nov=%0d required ovl>=nov", det_ovl, det_nov);
    end
    $display("[TB] soak detections ovl=%0d nov=%0d", det_ovl, det_nov);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
